// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues reads at the current PC and buffers {instr, pc, pc+4} for decode.
// Optional stall statistics counter is enabled with `define FETCH_QUEUE_STATS_EN.
module fetch_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               pc_value,
    output logic                       pc_enable,
    output logic                       imem_req,
    output logic [N-1:0]               imem_addr,
    input  logic [N-1:0]               imem_rdata,
    input  logic                       flush,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [N-1:0]               id_instr,
    output logic [N-1:0]               id_pc,
    output logic [N-1:0]               id_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [31:0]                stall_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0] count;
    logic          inflight;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [N-1:0]  req_pc;

    logic [N-1:0]  instr_mem [DEPTH];
    logic [N-1:0]  pc_mem    [DEPTH];
    logic [N-1:0]  pcp4_mem  [DEPTH];

    logic          deq;
    logic          issue;
    logic          write;
    logic [CW:0]   pending;

    // An outstanding request already owns a slot, so only issue when it cannot overflow.
    assign pending   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    assign issue     = !flush && (pending < (CW+1)'(DEPTH));
    assign deq       = id_valid && id_ready;
    assign write     = inflight && !flush;

    assign id_valid    = (count != '0) && !flush;
    assign imem_req    = issue;
    assign pc_enable   = issue || flush;
    assign imem_addr   = pc_value;
    assign id_instr    = instr_mem[rd_ptr];
    assign id_pc       = pc_mem[rd_ptr];
    assign id_pc_plus4 = pcp4_mem[rd_ptr];
    assign occupancy   = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            req_pc   <= '0;
        end else if (flush) begin
            count    <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                req_pc <= pc_value;
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
            if (write)
                wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(write) - CW'(deq);
        end
    end

    // Response data arrives one cycle after its request; req_pc remembers where it came from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
                pcp4_mem[i]  <= '0;
            end
        end else if (write) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= req_pc;
            pcp4_mem[wr_ptr]  <= req_pc + N'(4);
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (!pc_enable)
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: models the PC register and instruction memory,
// and predicts outputs with a queue-based reference model.
module tb_fetch_queue;

    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_value = '0;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [1:0]  occupancy;
    logic [31:0] stall_count;

    fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .pc_value(pc_value),
        .pc_enable(pc_enable),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .flush(flush),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_instr(id_instr),
        .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4),
        .occupancy(occupancy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    bit          pend;
    logic [31:0] mreq_pc;
    logic [31:0] pc_reg;
    logic [31:0] mem_data;
    bit          mem_valid;
    int          exp_stall;
    int          passed = 0;
    int          total = 0;
    bit          exp_valid, exp_deq, exp_issue;
    bit          seen_bad;

    logic        snap_valid, snap_req, snap_en;
    logic [31:0] snap_pc, snap_instr, snap_plus4, snap_addr, snap_stall;
    logic [1:0]  snap_occ;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0040_0000)
            return 32'h2008_0001;
        return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic resetModel();
        q.delete();
        pend      = 1'b0;
        mreq_pc   = '0;
        pc_reg    = 32'h0040_0000;
        mem_valid = 1'b0;
        mem_data  = '0;
        exp_stall = 0;
    endtask

    task automatic checkOutput();
        int occ;
        occ       = q.size();
        exp_valid = (occ != 0) && !flush;
        exp_deq   = exp_valid && id_ready;
        exp_issue = !flush && ((occ + int'(pend) - int'(exp_deq)) < DEPTH);
        chk("id_valid", id_valid, exp_valid);
        if (exp_valid) begin
            chk("id_instr", id_instr, q[0].instr);
            chk("id_pc", id_pc, q[0].pc);
            chk("id_pc_plus4", id_pc_plus4, q[0].pc + 32'd4);
        end
        chk("occupancy", occupancy, occ);
        chk("imem_req", imem_req, exp_issue);
        chk("pc_enable", pc_enable, exp_issue || flush);
        chk("imem_addr", imem_addr, pc_value);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stall_count", stall_count, exp_stall);
`else
        chk("stall_count", stall_count, 32'd0);
`endif
    endtask

    // One clock cycle: drive inputs, check, then advance the model and the environment.
    task automatic applyStimulus(input bit f, input bit rdy, input logic [31:0] tgt);
        logic [31:0] rdata_s;
        flush      = f;
        id_ready   = rdy;
        pc_value   = pc_reg;
        imem_rdata = mem_valid ? mem_data : $urandom;
        rdata_s    = imem_rdata;
        #1;
        checkOutput();
        snap_valid = id_valid;
        snap_pc    = id_pc;
        snap_instr = id_instr;
        snap_plus4 = id_pc_plus4;
        snap_occ   = occupancy;
        snap_req   = imem_req;
        snap_en    = pc_enable;
        snap_addr  = imem_addr;
        snap_stall = stall_count;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (exp_deq)
                void'(q.pop_front());
            if (pend)
                q.push_back('{instr: rdata_s, pc: mreq_pc});
            pend = exp_issue;
            if (exp_issue)
                mreq_pc = pc_value;
        end
        if (!(exp_issue || f))
            exp_stall++;
        if (snap_en)
            pc_reg = f ? tgt : pc_reg + 32'd4;
        mem_valid = snap_req;
        mem_data  = mem(snap_addr);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        #2;
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First fetch after reset and its two-cycle latency.
        applyStimulus(1'b0, 1'b1, '0);
        chk("first_addr", snap_addr, 32'h0040_0000);
        chk("first_req", snap_req, 1'b1);
        applyStimulus(1'b0, 1'b1, '0);
        chk("lat_valid_c1", snap_valid, 1'b0);
        applyStimulus(1'b0, 1'b1, '0);
        chk("lat_valid_c2", snap_valid, 1'b1);
        chk("lat_pc_c2", snap_pc, 32'h0040_0000);
        chk("lat_instr_c2", snap_instr, 32'h2008_0001);
        chk("lat_plus4_c2", snap_plus4, 32'h0040_0004);

        // Back-to-back streaming.
        for (int k = 3; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b1, '0);
            chk("stream_valid", snap_valid, 1'b1);
            chk("stream_pc", snap_pc, 32'h0040_0000 + 32'(4 * (k - 2)));
        end

        // Backpressure fills the queue and stalls the PC.
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b0, 1'b0, '0);
        chk("full_occ", snap_occ, 2'd2);
        chk("full_pc_enable", snap_en, 1'b0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("full_stall", snap_stall, 32'd5);
`else
        chk("full_stall", snap_stall, 32'd0);
`endif

        // Flush with a full queue.
        applyStimulus(1'b1, 1'b0, 32'h0040_0100);
        chk("flush_valid", snap_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, '0);
        chk("post_flush_occ", snap_occ, 2'd0);
        chk("post_flush_valid", snap_valid, 1'b0);
        chk("post_flush_addr", snap_addr, 32'h0040_0100);
        chk("post_flush_req", snap_req, 1'b1);

        // Flush in the response cycle of the 0x0040_0100 request.
        applyStimulus(1'b1, 1'b1, 32'h0040_0200);
        seen_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, '0);
            if (snap_valid && snap_pc == 32'h0040_0100)
                seen_bad = 1'b1;
            if (k == 2) begin
                chk("redirect_valid", snap_valid, 1'b1);
                chk("redirect_pc", snap_pc, 32'h0040_0200);
            end
        end
        chk("flushed_resp_absent", seen_bad, 1'b0);

        // Asynchronous reset with a full queue.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b0, 1'b0, '0);
        chk("pre_reset_occ", snap_occ, 2'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", id_valid, 1'b0);
        chk("async_rst_occ", occupancy, 2'd0);
        chk("async_rst_instr", id_instr, 32'd0);
        chk("async_rst_pc", id_pc, 32'd0);
        chk("async_rst_stall", stall_count, 32'd0);
        resetModel();
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, '0);
        chk("rerun_first_addr", snap_addr, 32'h0040_0000);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(0, 11) == 0,
                          $urandom_range(0, 3) != 0,
                          32'h0040_0000 + (32'($urandom_range(0, 1023)) << 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter N, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_value  input  N  current PC from the PC register.
REQ-006 SHALL have port pc_enable  output  1  load enable returned to the PC register.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  N  read address, equal to pc_value combinationally.
REQ-009 SHALL have port imem_rdata  input  N  read data, valid exactly one cycle after imem_req.
REQ-010 SHALL have port flush  input  1  redirect (branch/jump taken); the PC register loads the target this cycle.
REQ-011 SHALL have port id_ready  input  1  decode stage accepts the head entry.
REQ-012 SHALL have port id_valid  output  1  head entry valid.
REQ-013 SHALL have ports id_instr, id_pc, id_pc_plus4  output  N each  head entry fields.
REQ-014 SHALL have port occupancy  output  clog2(DEPTH+1)  stored entry count.
REQ-015 SHALL have port stall_count  output  32  cycles with pc_enable=0 (see Configuration).

Function
REQ-016 SHALL keep count (entries stored) and inflight (1 bit, request outstanding) registers; DEPTH-entry circular FIFO of {instr, pc, pc+4}.
REQ-017 SHALL define deq = id_valid && id_ready; issue = !flush && (count + inflight - deq < DEPTH).
REQ-018 SHALL drive imem_req = issue; pc_enable = issue || flush.
REQ-019 SHALL set inflight next = issue, and latch req_pc = pc_value when issue.
REQ-020 SHALL, in a cycle with inflight=1 and flush=0, write {imem_rdata, req_pc, req_pc+4 mod 2^N} at the tail.
REQ-021 SHALL make id_valid = (count != 0) && !flush, with id_* showing the head entry.
REQ-022 SHALL give fetch latency of 2: request in cycle t, id_valid in cycle t+2 at the earliest.
REQ-023 SHALL sustain one instruction per cycle when id_ready is held at 1.
REQ-024 SHALL leave count unchanged on simultaneous write and deq; increment on write only; decrement on deq only.
REQ-025 SHALL never overflow: a write into a full queue is impossible by REQ-017; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL, on flush, clear count and pointers to 0, clear inflight, and discard any response arriving that cycle; the head is not dequeued.
REQ-027 SHALL hold id_* stable while id_valid=1 and id_ready=0.
REQ-028 SHALL drive occupancy = count.

Reset
REQ-029 SHALL, while reset=0, force count=0, inflight=0, pointers=0, req_pc=0, storage=0, stall_count=0, with no dependence on clk.
REQ-030 SHALL, while reset=0, drive outputs id_valid=0, id_instr/id_pc/id_pc_plus4=0, occupancy=0.
REQ-031 SHALL issue its first request in the first cycle after reset release, at address 0x0040_0000.
REQ-032 SHALL, on reset assertion during operation, discard all entries and the outstanding request.

Configuration
REQ-033 SHALL, with macro FETCH_QUEUE_STATS_EN defined, increment stall_count (wrapping) in each cycle outside reset with pc_enable=0.
REQ-034 SHALL, without FETCH_QUEUE_STATS_EN, tie stall_count to 0 and instantiate no counter logic.

Verification
REQ-035 SHALL cover: reset release, id_ready=1, imem returns 0x2008_0001 -> cycle 0 imem_addr=0x0040_0000; cycle 2 id_valid=1, id_pc=0x0040_0000, id_pc_plus4=0x0040_0004.
REQ-036 SHALL cover: id_ready=0 for 6 cycles -> occupancy saturates at 2, pc_enable=0 thereafter, with stall_count advancing when FETCH_QUEUE_STATS_EN is defined.
REQ-037 SHALL cover: id_ready=1 continuously for 8 requests -> id_valid=1 every cycle from cycle 2, id_pc stepping by 4.
REQ-038 SHALL cover: queue full, flush=1 with target 0x0040_0100 -> next cycle occupancy=0, id_valid=0, imem_addr=0x0040_0100, imem_req=1.
REQ-039 SHALL cover: flush in the response cycle -> that response never appears on id_instr.
REQ-040 SHALL cover: reset asserted with occupancy=2 -> id_valid=0 and occupancy=0 immediately, before the next clk edge.
